div_seq_unit: RTL and testbench

- Multi-cycle unsigned integer divider for the 8-bit Harvard core's ALU execute stage.
- Sits between register-file operand read (upstream) and ALU result writeback (downstream).
- Accepts dividend and divisor on a start pulse, runs one restoring shift/subtract step per clock, and returns quotient, remainder and a divide-by-zero flag with a done pulse.
- Busy output lets the control unit stall instruction fetch while a division is in flight.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 22 ++
 rtl/div_seq_unit.sv | 116 +++++++++++
 tb/tb_div_seq_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the quotient reported on divide-by-zero.
package div_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    // Sliced down to WIDTH by users; all ones at any width up to 64.
    localparam logic [63:0] DZ_QUOT_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift/subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor if it fits.
module div_step #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_quo_msb,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_q_bit
);

    logic [W:0] w_shift;
    logic [W:0] w_trial;

    assign w_shift = {i_rem, i_quo_msb};
    // W+1 bits so a borrow out of the shifted MSB is visible in w_trial[W].
    assign w_trial = w_shift - {1'b0, i_divisor};
    assign o_q_bit = ~w_trial[W];
    assign o_rem   = o_q_bit ? w_trial[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle unsigned divider: one restoring step per clock, results
// registered and announced with a single-cycle done pulse.
module div_seq_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output state_t           dbg_state
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic             r_zero;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_q_bit;

    div_step #(.W(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo_msb (r_quo[WIDTH-1]),
        .i_divisor (r_div),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = (b == '0) ? ST_FIN : ST_RUN;
            ST_RUN:  if (r_cnt == CNT_W'(WIDTH - 1)) w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Working registers and output registers; q/r/dz only move in FIN,
    // except dz which is cleared when a new division is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_rem  <= '0;
            r_zero <= 1'b0;
            r_q    <= '0;
            r_r    <= '0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_quo  <= a;
                        r_div  <= b;
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_zero <= (b == '0);
                        r_dz   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt + 1'b1;
                end
                ST_FIN: begin
                    r_done <= 1'b1;
                    if (r_zero) begin
                        r_q  <= DZ_QUOT_ALL[WIDTH-1:0];
                        r_r  <= r_quo;
                        r_dz <= 1'b1;
                    end else begin
                        r_q <= r_quo;
                        r_r <= r_rem;
                    end
                end
                default: ;
            endcase
        end
    end

    assign q         = r_q;
    assign r         = r_r;
    assign done      = r_done;
    assign dz        = r_dz;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed table, random operands
// against an arithmetic reference, and multi-cycle corner sequences.
module tb_div_seq_unit;
  import div_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         dz;
  state_t       dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
  } vec_t;

  vec_t vecs[$];

  div_seq_unit #(.WIDTH(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .q         (q),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .dz        (dz),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] mq, output logic [W-1:0] mr, output logic mdz);
    int ia, ib;
    ia = int'(ma);
    ib = int'(mb);
    if (ib == 0) begin
      mq = {W{1'b1}};
      mr = ma;
      mdz = 1'b1;
    end else begin
      mq = W'(ia / ib);
      mr = W'(ia % ib);
      mdz = 1'b0;
    end
  endtask

  // Issue one division and follow it to completion, checking latency,
  // busy duration, the single done pulse and the results.
  task automatic run_div(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int edges;
    int busy_hi;
    int exp_edges;
    bit seen;
    exp_edges = (vb == '0) ? 1 : W + 1;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom_range(0, 255);
    b = $urandom_range(0, 255);
    edges = 0;
    busy_hi = 0;
    seen = 0;
    while (!seen && edges < 40) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
      end else begin
        if (busy) busy_hi++;
        @(posedge clk);
        edges++;
      end
    end
    chk({name, " done_seen"}, 32'(seen), 32'd1);
    chk({name, " latency"}, 32'(edges), 32'(exp_edges));
    chk({name, " busy_cycles"}, 32'(busy_hi), 32'(exp_edges));
    chk({name, " busy_at_done"}, 32'(busy), 32'd0);
    chk({name, " q"}, 32'(q), 32'(eq));
    chk({name, " r"}, 32'(r), 32'(er));
    chk({name, " dz"}, 32'(dz), 32'(edz));
    @(negedge clk);
    chk({name, " done_one_cycle"}, 32'(done), 32'd0);
    chk({name, " q_hold"}, 32'(q), 32'(eq));
  endtask

  task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    vec_t v;
    v.a = va; v.b = vb; v.exp_q = eq; v.exp_r = er; v.exp_dz = edz;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] ra, rb, mq, mr;
    logic         mdz;
    int           done_cnt;
    int           bad_busy;

    add_vec(8'd100, 8'd7,   8'd14,  8'd2,   1'b0);
    add_vec(8'd255, 8'd1,   8'd255, 8'd0,   1'b0);
    add_vec(8'd5,   8'd9,   8'd0,   8'd5,   1'b0);
    add_vec(8'd255, 8'd128, 8'd1,   8'd127, 1'b0);
    add_vec(8'd42,  8'd0,   8'hFF,  8'd42,  1'b1);
    add_vec(8'd42,  8'd6,   8'd7,   8'd0,   1'b0);
    add_vec(8'd0,   8'd0,   8'hFF,  8'd0,   1'b1);
    add_vec(8'd254, 8'd255, 8'd0,   8'd254, 1'b0);
    add_vec(8'd255, 8'd255, 8'd1,   8'd0,   1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset q", 32'(q), 32'd0);
    chk("reset r", 32'(r), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dz", 32'(dz), 32'd0);
    chk("reset state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
              vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dz);
    end

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = (i % 7 == 3) ? '0 : W'($urandom_range(1, 255));
      model(ra, rb, mq, mr, mdz);
      run_div($sformatf("rand%0d", i), ra, rb, mq, mr, mdz);
    end

    // Start while busy is ignored: 200/3 with 9/3 pulsed mid-run.
    @(negedge clk);
    a = 8'd200; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 8'd9; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("ignore q", 32'(q), 32'd66);
        chk("ignore r", 32'(r), 32'd2);
      end
    end
    chk("ignore done_pulses", 32'(done_cnt), 32'd1);

    // Asynchronous reset mid-run clears everything immediately.
    @(negedge clk);
    a = 8'd100; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst q", 32'(q), 32'd0);
    chk("arst r", 32'(r), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    chk("arst dz", 32'(dz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_div("post_rst", 8'd50, 8'd5, 8'd10, 8'd0, 1'b0);

    // Start held high: back-to-back 77/10, busy low only on done cycles.
    @(negedge clk);
    a = 8'd77; b = 8'd10; start = 1'b1;
    done_cnt = 0;
    bad_busy = 0;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("b2b q", 32'(q), 32'd7);
        chk("b2b r", 32'(r), 32'd7);
      end
      if (busy == done) bad_busy++;
    end
    start = 1'b0;
    chk("b2b done_pulses", 32'(done_cnt), 32'd3);
    chk("b2b busy_gap", 32'(bad_busy), 32'd0);
    repeat (12) @(negedge clk);
    chk("b2b idle_after", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
